// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit add/subtract computed DIGIT bits per clock
// through a single ripple-carry slice, valid/ready on input and output.
// Ports: clk; rst_n (synchronous, active low);
//   in_valid/in_ready, a, b, cin, sub  -- operand handshake
//   acc (only with DIGSER_ACC_EN)      -- use last delivered sum as A
//   out_valid/out_ready, sum, cout, ovf -- result handshake
// Optional feature macro: DIGSER_ACC_EN.
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef DIGSER_ACC_EN
  input  logic             acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             running;
  logic             last;
  logic [WIDTH-1:0] opa;
  logic [DIGIT-1:0] a_lo;
  logic [DIGIT-1:0] b_lo;
  logic [DIGIT:0]   slice;
  logic             msb_cin;
  logic [WIDTH+DIGIT-1:0] a_cat;
  logic [WIDTH+DIGIT-1:0] b_cat;
  logic [WIDTH+DIGIT-1:0] sh_cat;

  assign accept  = in_valid && (state_q == IDLE);
  assign running = (state_q == RUN);
  assign last    = (cnt_q == '0);

  // sum_q only changes on the final digit, so it still holds the
  // last delivered result while the machine is idle.
`ifdef DIGSER_ACC_EN
  assign opa = acc ? sum_q : a;
`else
  assign opa = a;
`endif

  // One DIGIT-bit ripple slice; the carry into its top bit is
  // recovered from the sum bit so overflow needs no extra adder.
  assign a_lo    = a_q[DIGIT-1:0];
  assign b_lo    = b_q[DIGIT-1:0];
  assign slice   = {1'b0, a_lo} + {1'b0, b_lo}
                 + {{DIGIT{1'b0}}, carry_q};
  assign msb_cin = a_lo[DIGIT-1] ^ b_lo[DIGIT-1]
                 ^ slice[DIGIT-1];

  // Wide concatenations keep the shifts legal when DIGIT == WIDTH.
  assign a_cat  = {{DIGIT{1'b0}}, a_q};
  assign b_cat  = {{DIGIT{1'b0}}, b_q};
  assign sh_cat = {slice[DIGIT-1:0], sh_q};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next values
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      accept: begin
        a_d     = opa;
        b_d     = sub ? ~b : b;
        carry_d = cin ^ sub;
        cnt_d   = CW'(NDIG - 1);
      end
      running: begin
        a_d     = a_cat[WIDTH+DIGIT-1:DIGIT];
        b_d     = b_cat[WIDTH+DIGIT-1:DIGIT];
        sh_d    = sh_cat[WIDTH+DIGIT-1:DIGIT];
        carry_d = slice[DIGIT];
        if (last) begin
          cnt_d  = '0;
          sum_d  = sh_cat[WIDTH+DIGIT-1:DIGIT];
          cout_d = slice[DIGIT];
          ovf_d  = msb_cin ^ slice[DIGIT];
        end else begin
          cnt_d  = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
